// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with a start/busy/done handshake and a synchronous flush.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [CW-1:0]       count_reg;
    logic [2:0]          op_reg;
    logic                neg_reg;
    logic [2*XLEN-1:0]   prod_reg;
    logic [XLEN-1:0]     mcand_reg;
    logic [XLEN:0]       rem_reg;
    logic [XLEN-1:0]     quot_reg;
    logic [XLEN-1:0]     divisor_reg;
    logic [XLEN-1:0]     result_reg;

    // Accept-time decode: signedness, magnitudes and divide special cases
    logic                accept;
    logic                is_div;
    logic                signed_a, signed_b;
    logic                a_neg, b_neg;
    logic [XLEN-1:0]     abs_a, abs_b;
    logic                div_zero, div_ovf, special;
    logic [XLEN-1:0]     special_val;
    logic                neg_flag;

    always_comb begin
        accept   = (state_reg == IDLE) && start && !flush;
        is_div   = op[2];
        signed_a = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        signed_b = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        a_neg    = signed_a && operand_a[XLEN-1];
        b_neg    = signed_b && operand_b[XLEN-1];
        abs_a    = a_neg ? (~operand_a + 1'b1) : operand_a;
        abs_b    = b_neg ? (~operand_b + 1'b1) : operand_b;
        div_zero = is_div && (operand_b == '0);
        div_ovf  = is_div && !op[0] && (operand_a == SMIN) && (operand_b == '1);
        special  = div_zero || div_ovf;

        special_val = '0;
        if (div_zero) begin
            special_val = op[1] ? operand_a : '1;
        end else begin
            special_val = op[1] ? '0 : SMIN;
        end

        // Remainder takes the dividend's sign; everything else the XOR
        neg_flag = (is_div && op[1]) ? a_neg : (a_neg ^ b_neg);
    end

    // One iteration of the multiply and divide datapaths
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   prod_step;
    logic [XLEN:0]       div_shift;
    logic [XLEN:0]       div_diff;
    logic                div_fits;
    logic [XLEN:0]       rem_step;
    logic [XLEN-1:0]     quot_step;
    logic [2*XLEN-1:0]   prod_signed;
    logic [XLEN-1:0]     quot_signed;
    logic [XLEN-1:0]     rem_signed;
    logic [XLEN-1:0]     final_val;
    logic                last_iter;

    always_comb begin
        mul_sum   = {1'b0, prod_reg[2*XLEN-1:XLEN]}
                  + (prod_reg[0] ? {1'b0, mcand_reg} : {(XLEN+1){1'b0}});
        prod_step = {mul_sum, prod_reg[XLEN-1:1]};

        div_shift = {rem_reg[XLEN-1:0], quot_reg[XLEN-1]};
        div_diff  = div_shift - {1'b0, divisor_reg};
        div_fits  = !div_diff[XLEN];
        rem_step  = div_fits ? div_diff : div_shift;
        quot_step = {quot_reg[XLEN-2:0], div_fits};

        // The full product is negated before the high half is picked
        prod_signed = neg_reg ? (~prod_step + 1'b1) : prod_step;
        quot_signed = neg_reg ? (~quot_step + 1'b1) : quot_step;
        rem_signed  = neg_reg ? (~rem_step[XLEN-1:0] + 1'b1) : rem_step[XLEN-1:0];

        case (op_reg)
            OP_MUL:                       final_val = prod_signed[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_val = prod_signed[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              final_val = quot_signed;
            default:                      final_val = rem_signed;
        endcase

        last_iter = (state_reg == CALC) && (count_reg == CW'(1));
    end

    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_next = special ? DONE : CALC;
                    end
                end
                CALC: begin
                    if (count_reg == CW'(1)) begin
                        state_next = DONE;
                    end
                end
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg   <= '0;
            op_reg      <= '0;
            neg_reg     <= 1'b0;
            prod_reg    <= '0;
            mcand_reg   <= '0;
            rem_reg     <= '0;
            quot_reg    <= '0;
            divisor_reg <= '0;
            result_reg  <= '0;
        end else if (accept) begin
            op_reg      <= op;
            neg_reg     <= neg_flag;
            count_reg   <= CW'(XLEN);
            prod_reg    <= {{XLEN{1'b0}}, abs_b};
            mcand_reg   <= abs_a;
            rem_reg     <= '0;
            quot_reg    <= abs_a;
            divisor_reg <= abs_b;
            if (special) begin
                result_reg <= special_val;
            end
        end else if ((state_reg == CALC) && !flush) begin
            count_reg <= count_reg - CW'(1);
            if (op_reg[2]) begin
                rem_reg  <= rem_step;
                quot_reg <= quot_step;
            end else begin
                prod_reg <= prod_step;
            end
            if (last_iter) begin
                result_reg <= final_val;
            end
        end
    end

    assign busy   = (state_reg != IDLE);
    assign done   = (state_reg == DONE);
    assign result = result_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised and directed bench for muldiv_unit at XLEN=32 and XLEN=16, checked
// against an arithmetic reference model of the RV32M operations.
module tb_muldiv_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start, flush;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] result;

    logic        start16, flush16;
    logic [2:0]  op16;
    logic [15:0] a16, b16;
    logic        busy16, done16;
    logic [15:0] result16;

    int checks   = 0;
    int failures = 0;

    muldiv_unit #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .operand_a(a), .operand_b(b), .flush(flush),
        .busy(busy), .done(done), .result(result)
    );

    muldiv_unit #(.XLEN(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .op(op16),
        .operand_a(a16), .operand_b(b16), .flush(flush16),
        .busy(busy16), .done(done16), .result(result16)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain wide-integer arithmetic on w-bit operands
    function automatic logic [63:0] model(input logic [2:0] o, input logic [63:0] x,
                                          input logic [63:0] y, input int w);
        logic signed [127:0] ux, uy, sx, sy, p, m, smin;
        ux   = 128'(x);
        uy   = 128'(y);
        m    = (128'sd1 <<< w) - 128'sd1;
        smin = 128'sd1 <<< (w - 1);
        sx   = x[w-1] ? ux - (m + 128'sd1) : ux;
        sy   = y[w-1] ? uy - (m + 128'sd1) : uy;
        case (o)
            3'd0: begin p = ux * uy; return 64'(p & m); end
            3'd1: begin p = sx * sy; return 64'((p >>> w) & m); end
            3'd2: begin p = sx * uy; return 64'((p >>> w) & m); end
            3'd3: begin p = ux * uy; return 64'((p >>> w) & m); end
            3'd4: begin
                if (uy == 0) return 64'(m);
                if (ux == smin && uy == m) return 64'(smin);
                return 64'((sx / sy) & m);
            end
            3'd5: begin
                if (uy == 0) return 64'(m);
                return 64'((ux / uy) & m);
            end
            3'd6: begin
                if (uy == 0) return 64'(ux);
                if (ux == smin && uy == m) return 64'd0;
                return 64'((sx % sy) & m);
            end
            default: begin
                if (uy == 0) return 64'(ux);
                return 64'(ux % uy);
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] o, input logic [63:0] x,
                                      input logic [63:0] y, input int w);
        logic [63:0] m64;
        m64 = (64'd1 << w) - 64'd1;
        return o[2] && ((y == 0) || (!o[0] && x == (64'd1 << (w - 1)) && y == m64));
    endfunction

    function automatic logic get_busy(input int w);
        return (w == 16) ? busy16 : busy;
    endfunction

    function automatic logic get_done(input int w);
        return (w == 16) ? done16 : done;
    endfunction

    function automatic logic [63:0] get_result(input int w);
        return (w == 16) ? 64'(result16) : 64'(result);
    endfunction

    task automatic drive(input int w, input logic s, input logic [2:0] o,
                         input logic [63:0] x, input logic [63:0] y);
        if (w == 16) begin
            start16 = s; op16 = o; a16 = x[15:0]; b16 = y[15:0];
        end else begin
            start = s; op = o; a = x[31:0]; b = y[31:0];
        end
    endtask

    // Called just after E0; returns the edge index after which done was seen
    task automatic wait_done(input int w, output int n, output int bc, output bit seen);
        n = 0; bc = 0; seen = 1'b0;
        while (n <= w + 4) begin
            #1;
            if (get_busy(w)) bc++;
            if (get_done(w)) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            n++;
        end
    endtask

    task automatic run_op(input int w, input logic [2:0] o, input logic [63:0] x,
                          input logic [63:0] y, input string tag);
        logic [63:0] exp;
        int n, bc, exp_n;
        bit seen;
        exp   = model(o, x, y, w);
        exp_n = is_special(o, x, y, w) ? 0 : w;
        @(negedge clk);
        drive(w, 1'b1, o, x, y);
        @(posedge clk);
        wait_done(w, n, bc, seen);
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_latency"}, 64'(n), 64'(exp_n));
        check({tag, "_result"}, get_result(w), exp);
        $display("txn w=%0d op=%0d a=%0h b=%0h result=%0h exp=%0h edges=%0d",
                 w, o, x, y, get_result(w), exp, n);
        @(negedge clk);
        drive(w, 1'b0, o, x, y);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 64'(get_done(w)), 64'd0);
        check({tag, "_busy_idle"}, 64'(get_busy(w)), 64'd0);
        check({tag, "_busy_cycles"}, 64'(bc), 64'(exp_n + 1));
        check({tag, "_result_held"}, get_result(w), exp);
    endtask

    task automatic rand_operands(input int w, output logic [63:0] x, output logic [63:0] y);
        logic [63:0] m64;
        int kind;
        m64  = (64'd1 << w) - 64'd1;
        kind = $urandom_range(0, 5);
        x = {32'($urandom), 32'($urandom)} & m64;
        y = {32'($urandom), 32'($urandom)} & m64;
        case (kind)
            0: y = 64'd0;
            1: begin x = 64'd1 << (w - 1); y = m64; end
            2: begin x = x & 64'hFF; y = 64'($urandom_range(1, 15)); end
            default: ;
        endcase
    endtask

    initial begin
        logic [63:0] x, y;
        int n, bc, dcount;
        bit seen;

        rst_n = 1'b0;
        flush = 1'b0; flush16 = 1'b0;
        drive(32, 1'b0, 3'd0, 64'd0, 64'd0);
        drive(16, 1'b0, 3'd0, 64'd0, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases from the operation table
        run_op(32, 3'd0, 64'd7, 64'hFFFFFFFD, "mul_7_m3");
        check("mul_7_m3_const", 64'(result), 64'hFFFFFFEB);
        run_op(32, 3'd1, 64'h80000000, 64'h80000000, "mulh_min");
        check("mulh_min_const", 64'(result), 64'h40000000);
        run_op(32, 3'd3, 64'hFFFFFFFF, 64'hFFFFFFFF, "mulhu_max");
        check("mulhu_max_const", 64'(result), 64'hFFFFFFFE);
        run_op(32, 3'd2, 64'hFFFFFFFF, 64'hFFFFFFFF, "mulhsu_m1");
        check("mulhsu_m1_const", 64'(result), 64'hFFFFFFFF);
        run_op(32, 3'd4, 64'hFFFFFFF9, 64'd2, "div_m7_2");
        check("div_m7_2_const", 64'(result), 64'hFFFFFFFD);
        run_op(32, 3'd6, 64'hFFFFFFF9, 64'd2, "rem_m7_2");
        check("rem_m7_2_const", 64'(result), 64'hFFFFFFFF);
        run_op(32, 3'd5, 64'd100, 64'd7, "divu_100_7");
        check("divu_100_7_const", 64'(result), 64'd14);
        run_op(32, 3'd7, 64'd100, 64'd7, "remu_100_7");
        check("remu_100_7_const", 64'(result), 64'd2);
        run_op(32, 3'd5, 64'd5, 64'd0, "divu_by0");
        check("divu_by0_const", 64'(result), 64'hFFFFFFFF);
        run_op(32, 3'd7, 64'd5, 64'd0, "remu_by0");
        check("remu_by0_const", 64'(result), 64'd5);
        run_op(32, 3'd4, 64'h80000000, 64'hFFFFFFFF, "div_ovf");
        check("div_ovf_const", 64'(result), 64'h80000000);
        run_op(32, 3'd6, 64'h80000000, 64'hFFFFFFFF, "rem_ovf");
        check("rem_ovf_const", 64'(result), 64'd0);

        // Start held through CALC with changed operands must not be re-sampled
        @(negedge clk);
        drive(32, 1'b1, 3'd5, 64'd100, 64'd7);
        @(posedge clk);
        @(negedge clk);
        drive(32, 1'b1, 3'd5, 64'd1000, 64'd3);
        wait_done(32, n, bc, seen);
        check("hold_done_seen", 64'(seen), 64'd1);
        check("hold_latency", 64'(n), 64'd32);
        check("hold_result", 64'(result), model(3'd5, 64'd100, 64'd7, 32));
        $display("txn w=32 held-start divu result=%0h edges=%0d", result, n);
        @(negedge clk);
        drive(32, 1'b0, 3'd0, 64'd0, 64'd0);
        @(posedge clk);

        // Flush at iteration 10 of a multiply
        run_op(32, 3'd0, 64'd7, 64'hFFFFFFFD, "pre_flush");
        @(negedge clk);
        drive(32, 1'b1, 3'd0, 64'd123, 64'd456);
        @(posedge clk);
        @(negedge clk);
        drive(32, 1'b0, 3'd0, 64'd123, 64'd456);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        check("flush_busy", 64'(busy), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        dcount = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) dcount++;
        end
        check("flush_no_done", 64'(dcount), 64'd0);
        check("flush_result_kept", 64'(result), 64'hFFFFFFEB);
        $display("txn w=32 flushed mul result=%0h", result);

        // flush and start together in IDLE: start dropped
        @(negedge clk);
        flush = 1'b1;
        drive(32, 1'b1, 3'd5, 64'd5, 64'd0);
        @(posedge clk);
        #1;
        check("flush_start_busy", 64'(busy), 64'd0);
        check("flush_start_done", 64'(done), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        drive(32, 1'b0, 3'd0, 64'd0, 64'd0);
        @(posedge clk);
        #1;
        check("flush_start_idle", 64'(busy), 64'd0);
        check("flush_start_result", 64'(result), 64'hFFFFFFEB);
        $display("txn w=32 flush+start result=%0h", result);

        // Asynchronous reset mid-CALC
        @(negedge clk);
        drive(32, 1'b1, 3'd0, 64'd5, 64'd6);
        @(posedge clk);
        @(negedge clk);
        drive(32, 1'b0, 3'd0, 64'd5, 64'd6);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_done", 64'(done), 64'd0);
        check("async_rst_result", 64'(result), 64'd0);
        $display("txn w=32 async reset result=%0h", result);
        @(negedge clk);
        rst_n = 1'b1;

        // Narrow datapath
        run_op(16, 3'd3, 64'hFFFF, 64'hFFFF, "mulhu16");
        check("mulhu16_const", 64'(result16), 64'hFFFE);

        for (int i = 0; i < 120; i++) begin
            rand_operands(32, x, y);
            run_op(32, 3'($urandom_range(0, 7)), x, y, "rand32");
        end
        for (int i = 0; i < 40; i++) begin
            rand_operands(16, x, y);
            run_op(16, 3'($urandom_range(0, 7)), x, y, "rand16");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
